// File: rtl/adc_spi_responder_if.sv
// ---------------------------------------------------------------------------
// adc_spi_responder_if
//   Four-wire link between the ADC reader and the emulated 8-channel ADC.
//
//   Signals:
//     ADC_CS_N  frame select, low while a frame is active
//     ADC_SCLK  serial clock; idles low, config sampled on its rising edge
//     ADC_DIN   config bits toward the converter, MSB first
//     ADC_DOUT  conversion bits from the converter, MSB first,
//               changed after each SCLK falling edge
//
//   Modports:
//     master  the reader side (drives CS_N/SCLK/DIN, receives DOUT)
//     slave   the converter side (receives CS_N/SCLK/DIN, drives DOUT)
// ---------------------------------------------------------------------------
interface adc_spi_responder_if;
  logic ADC_CS_N;
  logic ADC_SCLK;
  logic ADC_DIN;
  logic ADC_DOUT;

  modport master (
    output ADC_CS_N,
    output ADC_SCLK,
    output ADC_DIN,
    input  ADC_DOUT
  );

  modport slave (
    input  ADC_CS_N,
    input  ADC_SCLK,
    input  ADC_DIN,
    output ADC_DOUT
  );
endinterface

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
//   Emulates the on-board 8-channel 12-bit SPI ADC so the capture path can be
//   exercised without an analog front end. Each frame returns the data of the
//   channel chosen by the previous frame's config word, the same pipelined
//   behaviour as the real converter.
//
//   Ports:
//     clock        system clock, all logic on its rising edge
//     reset_n      asynchronous active-low reset
//     spi          adc_spi_responder_if.slave (CS_N, SCLK, DIN in; DOUT out);
//                  the pins are asynchronous to clock and get synchronized
//     ch_data      flat channel data, CHn in bits [n*CH_W +: CH_W]
//     cur_ch       channel returned by the current or next frame
//     frame_done   one-cycle pulse when a full frame ends with CS_N rising
//     frame_abort  one-cycle pulse when CS_N rises before the last bit
//
//   Config word (MSB first): S/D, O/S, S1, S0, UNI, SLP.
//     cur_ch = {S1, S0, O/S}; S/D=0 forces the returned data to zero;
//     SLP is ignored.
//
//   Build option ADC_RESP_BIPOLAR_EN:
//     defined   - a committed UNI=0 flips the data MSB, turning offset
//                 binary into two's complement
//     undefined - UNI is stored but data is always returned as is
// ---------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int CH_W = 12,
  parameter int NCH  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  adc_spi_responder_if.slave  spi,
  input  logic [NCH*CH_W-1:0] ch_data,
  output logic [2:0]          cur_ch,
  output logic                frame_done,
  output logic                frame_abort
);

  localparam int         CNT_W     = $clog2(CH_W + 1);
  localparam int         CFG_W     = 6;
  localparam logic [5:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t            state, state_next;
  logic [CH_W-1:0]   shift_reg, shift_reg_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [CFG_W-1:0]  cfg_sr, cfg_sr_next;
  logic [CFG_W-1:0]  cfg_reg, cfg_next;
  logic              dout, dout_next;
  logic              done_next, abort_next;
  logic [CH_W-1:0]   snap;

  // Two sync stages plus one history stage for the edge-carrying pins.
  // CS_N resets high and SCLK low (their idle levels) so no false edge is
  // seen right after reset release.
  logic [2:0] cs_pipe;
  logic [2:0] sclk_pipe;
  logic [1:0] din_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_pipe   <= 3'b111;
      sclk_pipe <= 3'b000;
      din_pipe  <= 2'b00;
    end else begin
      cs_pipe   <= {cs_pipe[1:0], spi.ADC_CS_N};
      sclk_pipe <= {sclk_pipe[1:0], spi.ADC_SCLK};
      din_pipe  <= {din_pipe[0], spi.ADC_DIN};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, din_s;

  assign cs_fall   =  cs_pipe[2]   & ~cs_pipe[1];
  assign cs_rise   = ~cs_pipe[2]   &  cs_pipe[1];
  assign sclk_rise = ~sclk_pipe[2] &  sclk_pipe[1];
  assign sclk_fall =  sclk_pipe[2] & ~sclk_pipe[1];
  assign din_s     =  din_pipe[1];

  // Channel decode from the committed config: {S1, S0, O/S}.
  assign cur_ch = {cfg_reg[3], cfg_reg[2], cfg_reg[4]};

  // Word loaded into the shift register at the start of a frame.
  // A differential selection always reads as zero.
  always_comb begin
    snap = ch_data[int'(cur_ch)*CH_W +: CH_W];
`ifdef ADC_RESP_BIPOLAR_EN
    if (!cfg_reg[1]) begin
      snap = snap ^ {1'b1, {(CH_W-1){1'b0}}};
    end
`endif
    if (!cfg_reg[5]) begin
      snap = '0;
    end
  end

  // SLP never matters, and UNI only matters with the bipolar option.
  logic unused_cfg;
`ifdef ADC_RESP_BIPOLAR_EN
  assign unused_cfg = cfg_reg[0];
`else
  assign unused_cfg = ^{cfg_reg[1], cfg_reg[0]};
`endif

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      cfg_sr      <= '0;
      cfg_reg     <= CFG_RESET;
      dout        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_reg_next;
      bit_cnt     <= bit_cnt_next;
      cfg_sr      <= cfg_sr_next;
      cfg_reg     <= cfg_next;
      dout        <= dout_next;
      frame_done  <= done_next;
      frame_abort <= abort_next;
    end
  end

  // Next-state and datapath logic. The config is committed only when CS_N
  // rises after all CH_W rising edges; an early rise throws away the
  // partially shifted config and keeps the previous channel.
  always_comb begin
    state_next     = state;
    shift_reg_next = shift_reg;
    bit_cnt_next   = bit_cnt;
    cfg_sr_next    = cfg_sr;
    cfg_next       = cfg_reg;
    dout_next      = dout;
    done_next      = 1'b0;
    abort_next     = 1'b0;

    case (state)
      IDLE: begin
        dout_next = 1'b0;
        if (cs_fall) begin
          shift_reg_next = snap;
          dout_next      = snap[CH_W-1];
          bit_cnt_next   = '0;
          cfg_sr_next    = '0;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          dout_next  = 1'b0;
          state_next = IDLE;
          if (bit_cnt == CNT_W'(CH_W)) begin
            cfg_next  = cfg_sr;
            done_next = 1'b1;
          end else begin
            abort_next = 1'b1;
          end
        end else if (bit_cnt == CNT_W'(CH_W)) begin
          dout_next  = 1'b0;
          state_next = HOLD;
        end else if (sclk_rise) begin
          if (bit_cnt < CNT_W'(CFG_W)) begin
            cfg_sr_next = {cfg_sr[CFG_W-2:0], din_s};
          end
          bit_cnt_next = bit_cnt + 1'b1;
        end else if (sclk_fall) begin
          shift_reg_next = {shift_reg[CH_W-2:0], 1'b0};
          dout_next      = shift_reg[CH_W-2];
        end
      end

      HOLD: begin
        dout_next = 1'b0;
        if (cs_rise) begin
          cfg_next   = cfg_sr;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        dout_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign spi.ADC_DOUT = dout;

endmodule

// File: tb/tb_adc_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_responder
//   Directed bench for adc_spi_responder. Acts as the ADC reader (SCLK idles
//   low, phases of 5 clocks), keeps its own model of the committed config and
//   channel data, pushes the expected word of each frame into a queue when the
//   frame starts and compares it with the word shifted out of DOUT.
//   Follows ADC_RESP_BIPOLAR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_adc_spi_responder;

  localparam int CH_W = 12;
  localparam int NCH  = 8;

  logic                clock;
  logic                reset_n;
  logic [NCH*CH_W-1:0] ch_data;
  logic [2:0]          cur_ch;
  logic                frame_done;
  logic                frame_abort;

  adc_spi_responder_if spi_bus ();

  adc_spi_responder #(.CH_W(CH_W), .NCH(NCH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .spi         (spi_bus),
    .ch_data     (ch_data),
    .cur_ch      (cur_ch),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  // 50 MHz system clock.
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Channel data as seen by the model, flattened onto the DUT input.
  logic [CH_W-1:0] chd [NCH];

  always_comb begin
    ch_data = '0;
    for (int n = 0; n < NCH; n++) begin
      ch_data[n*CH_W +: CH_W] = chd[n];
    end
  end

  // Pulse counters; a stuck-high pulse shows up as a delta above one.
  int done_cnt  = 0;
  int abort_cnt = 0;

  always @(posedge clock) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  logic [5:0]      m_cfg;
  logic [CH_W-1:0] exp_q [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ch_of(input logic [5:0] c);
    return {c[3], c[2], c[4]};
  endfunction

  // Expected word for a frame started under the current model config.
  function automatic logic [CH_W-1:0] model_word();
    logic [CH_W-1:0] d;
    d = chd[ch_of(m_cfg)];
`ifdef ADC_RESP_BIPOLAR_EN
    if (!m_cfg[1]) d = d ^ 12'h800;
`endif
    if (!m_cfg[5]) d = '0;
    return d;
  endfunction

  function automatic logic [5:0] cfg_for(input logic [2:0] a);
    return {1'b1, a[0], a[2], a[1], 1'b1, 1'b0};
  endfunction

  // One reader frame of nbits SCLK periods; DOUT is sampled just before
  // each rising edge, five clocks after the preceding falling edge.
  task automatic apply_stimulus(input logic [5:0] cfg, input int nbits, output logic [CH_W-1:0] rx);
    rx = '0;
    @(negedge clock);
    spi_bus.ADC_CS_N = 1'b0;
    repeat (5) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      spi_bus.ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (5) @(negedge clock);
      rx = {rx[CH_W-2:0], spi_bus.ADC_DOUT};
      spi_bus.ADC_SCLK = 1'b1;
      repeat (5) @(negedge clock);
      spi_bus.ADC_SCLK = 1'b0;
    end
    spi_bus.ADC_DIN = 1'b0;
    repeat (5) @(negedge clock);
    spi_bus.ADC_CS_N = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic run_frame(input string tag, input logic [5:0] cfg, input int nbits);
    int              d0, a0;
    logic [2:0]      ch_before;
    logic [CH_W-1:0] rx, exp;
    d0        = done_cnt;
    a0        = abort_cnt;
    ch_before = ch_of(m_cfg);
    if (nbits == CH_W) exp_q.push_back(model_word());
    apply_stimulus(cfg, nbits, rx);
    if (nbits == CH_W) begin
      exp = exp_q.pop_front();
      check_output($sformatf("%s data", tag), 32'(rx), 32'(exp));
      check_output($sformatf("%s done", tag), 32'(done_cnt - d0), 32'd1);
      check_output($sformatf("%s abort", tag), 32'(abort_cnt - a0), 32'd0);
      m_cfg = cfg;
      check_output($sformatf("%s cur_ch", tag), 32'(cur_ch), 32'(ch_of(m_cfg)));
    end else begin
      check_output($sformatf("%s abort", tag), 32'(abort_cnt - a0), 32'd1);
      check_output($sformatf("%s done", tag), 32'(done_cnt - d0), 32'd0);
      check_output($sformatf("%s cur_ch", tag), 32'(cur_ch), 32'(ch_before));
    end
  endtask

  initial begin
    int              d0, a0;
    logic [CH_W-1:0] rx;

    reset_n          = 1'b0;
    spi_bus.ADC_CS_N = 1'b1;
    spi_bus.ADC_SCLK = 1'b0;
    spi_bus.ADC_DIN  = 1'b0;
    for (int n = 0; n < NCH; n++) chd[n] = 12'(12'h101 * n);
    chd[0] = 12'hA5C;
    m_cfg  = 6'b100010;

    repeat (3) @(negedge clock);
    check_output("reset dout", 32'(spi_bus.ADC_DOUT), 32'd0);
    check_output("reset cur_ch", 32'(cur_ch), 32'd0);
    check_output("reset done", 32'(frame_done), 32'd0);
    check_output("reset abort", 32'(frame_abort), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    $display("[TB] basic frame and channel pipeline");
    run_frame("first", 6'b100010, CH_W);
    run_frame("select ch1", 6'b110010, CH_W);
    chd[1] = 12'h123;
    run_frame("sweep 0", cfg_for(3'd0), CH_W);
    chd[1] = 12'h101;

    $display("[TB] address sweep");
    for (int a = 1; a < NCH; a++) begin
      run_frame($sformatf("sweep %0d", a), cfg_for(3'(a)), CH_W);
    end
    run_frame("after sweep", cfg_for(3'd2), CH_W);

    $display("[TB] early CS_N rise");
    run_frame("abort ch5", cfg_for(3'd5), 5);

    $display("[TB] bipolar and differential");
    run_frame("uni0 ch0", 6'b100000, CH_W);
    chd[0] = 12'h800;
    run_frame("bipolar", 6'b011010, CH_W);
    run_frame("differential", 6'b110110, CH_W);
    check_output("exp ch3", 32'(cur_ch), 32'd3);

    $display("[TB] reset in mid-frame");
    chd[3] = 12'hFFF;
    d0 = done_cnt;
    a0 = abort_cnt;
    @(negedge clock);
    spi_bus.ADC_CS_N = 1'b0;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 7; i++) begin
      spi_bus.ADC_DIN = (i < 6) ? m_cfg[5-i] : 1'b0;
      repeat (5) @(negedge clock);
      spi_bus.ADC_SCLK = 1'b1;
      repeat (5) @(negedge clock);
      spi_bus.ADC_SCLK = 1'b0;
    end
    repeat (5) @(negedge clock);
    check_output("pre-reset dout", 32'(spi_bus.ADC_DOUT), 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("mid reset dout", 32'(spi_bus.ADC_DOUT), 32'd0);
    check_output("mid reset cur_ch", 32'(cur_ch), 32'd0);
    spi_bus.ADC_CS_N = 1'b1;
    spi_bus.ADC_DIN  = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check_output("reset no done", 32'(done_cnt - d0), 32'd0);
    check_output("reset no abort", 32'(abort_cnt - a0), 32'd0);
    m_cfg  = 6'b100010;
    chd[0] = 12'hABC;
    run_frame("post-reset", 6'b100010, CH_W);

    // A channel data change during a frame must not reach DOUT.
    exp_q.push_back(model_word());
    fork
      apply_stimulus(6'b100010, CH_W, rx);
      begin
        repeat (40) @(negedge clock);
        chd[0] = 12'h0F0;
      end
    join
    check_output("snapshot held", 32'(rx), 32'(exp_q.pop_front()));
    check_output("queue empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI responder that emulates the on-board 8-channel 12-bit ADC, sitting on the far end of the ADC_CS_N/ADC_SCLK/ADC_DIN/ADC_DOUT link driven by the ADC reader. It decodes the 6-bit channel-select word shifted in on ADC_DIN and returns 12-bit conversion data for the channel selected in the previous frame, matching the pipelined behaviour of the real converter. It supports loopback bring-up and regression of the scope's capture path without an analog front end: the sine generator or test patterns are fed in as channel data.

## Interface
- CH_W, 12: channel data width; also the frame length in SCLK cycles.
- NCH, 8: number of emulated channels; fixed at 8, since the 3-bit channel address is decoded.

- clock  in  1  system clock, 50 MHz; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset; one clock (clock), no other clock domains.
- ADC_CS_N  in  1  frame select from the reader; low means frame active. Asynchronous to clock.
- ADC_SCLK  in  1  serial clock from the reader. Asynchronous to clock.
- ADC_DIN  in  1  config bits, MSB first, sampled on SCLK rising edge.
- ADC_DOUT  out  1  result bits, MSB first, updated on SCLK falling edge.
- ch_data  in  NCH*CH_W  flat channel data; CHn occupies bits [n*12+11 : n*12].
- cur_ch  out  3  channel whose data the current or next frame returns.
- frame_done  out  1  one-cycle pulse when a full 12-bit frame completes.
- frame_abort  out  1  one-cycle pulse when CS_N rises before bit 12.

## Operation
- ADC_CS_N, ADC_SCLK and ADC_DIN each pass through a 2-flop synchronizer. A third register per signal provides edge detection: cs_fall, cs_rise, sclk_rise, sclk_fall.
- State machine:
  - IDLE: DOUT=0. On cs_fall: snapshot ch_data[cur_ch] into the 12-bit shift register, drive its MSB on DOUT, clear bit_cnt and cfg_sr, go to SHIFT.
  - SHIFT: on sclk_rise, cfg_sr <= {cfg_sr[4:0], din_s} while bit_cnt<6, and bit_cnt++. On sclk_fall with bit_cnt<12, shift left and drive the next bit; zero fill. When bit_cnt reaches 12, go to HOLD.
  - HOLD: DOUT=0; extra SCLK edges are ignored. On cs_rise, commit the config, pulse frame_done, go to IDLE.
  - A cs_rise in SHIFT pulses frame_abort, discards cfg_sr, leaves cur_ch and the mode unchanged, and goes to IDLE.
- Config word, MSB first: S/D, O/S, S1, S0, UNI, SLP.
  - Channel commit: cur_ch <= {S1, S0, O/S}. This gives single-ended mapping 000→CH0, 100→CH1, 001→CH2, … 111→CH7.
  - S/D=0 (differential) is still committed, but the returned data is forced to 12'h000.
  - SLP is ignored.
- The snapshot happens only at cs_fall. Changes on ch_data during a frame do not affect it.
- A cs_fall while in HOLD, where cs_rise was missed, is impossible after synchronization. If the reader glitches CS_N, it is handled as cs_rise followed by cs_fall on successive edges.

## Timing
- Reset values:
  - ADC_DOUT=0, cur_ch=0, committed config=6'b100010 (single-ended, CH0, unipolar).
  - frame_done=0, frame_abort=0, state=IDLE, bit_cnt=0.
- Input-to-DOUT latency: 3 clock cycles from a pin edge (CS_N fall or SCLK fall) to DOUT update.
  - The reader must not sample DOUT sooner than 4 clocks after the SCLK fall.
- Each SCLK high and low phase must be ≥4 clock cycles, i.e. SCLK ≤ clock/8 (6.25 MHz at 50 MHz).
- CS_N must stay high ≥4 clocks between frames.
- frame_done and frame_abort assert for exactly 1 cycle, 3–4 clocks after the CS_N rising pin edge.
- cur_ch updates in the same cycle as frame_done. The new channel is used starting with the next cs_fall.
- Asserting reset_n low mid-frame forces all reset values immediately. The frame restarts only on a fresh cs_fall after reset release.

## Configuration
- ADC_RESP_BIPOLAR_EN
  - Defined: when the committed UNI=0 (bipolar), the snapshot is ch_data[cur_ch] ^ 12'h800, converting offset-binary to two's complement. When UNI=1, data is returned unchanged.
  - Undefined: the UNI bit is decoded but has no effect, and all data is returned as straight binary.

## Test plan
- Reset, then one frame with DIN=6'b100010 and CH0=12'hA5C → DOUT reads 12'hA5C MSB first; frame_done pulses once; cur_ch=0.
- Frame 1 with DIN=6'b110010, then frame 2 with CH1=12'h123 → frame 1 returns CH0; frame 2 returns 12'h123; cur_ch=1 after frame 1.
- Sweep all 8 addresses with CHn=12'h100*n+n → each subsequent frame returns the value of the mapped channel; 111 yields CH7=12'h707.
- Raise CS_N after 5 SCLKs with DIN selecting CH5 → frame_abort pulses, no frame_done, cur_ch unchanged, next frame returns the prior channel.
- With ADC_RESP_BIPOLAR_EN defined, DIN=6'b100000 and CH0=12'h800 → the next frame returns 12'h000. Without the macro → it returns 12'h800.
- Assert reset_n at bit 7 of a frame → DOUT=0 and cur_ch=0 immediately; a new frame after release returns a full 12-bit CH0 value.
